// File: rtl/spi_target_regfile.sv
// rtl/spi_target_regfile.sv - SPI mode-0 target exposing a small 8-bit register file (option: SPI_TGT_AUTOINC_EN)
module spi_target_regfile #(
  parameter int NumRegs = 16,
  parameter int SyncStages = 2,
  parameter logic [NumRegs-1:0][7:0] ResetVal = '0,
  localparam int AddrW = $clog2(NumRegs)
) (
  input  logic             soc_clk,
  input  logic             rst_n,
  input  logic             spi_sck_i,
  input  logic             spi_csb_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             spi_miso_oe_o,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o,
  output logic             wr_valid_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  localparam logic [7:0]     NumRegsB = 8'(NumRegs);
  localparam logic [AddrW:0] NumRegsA = (AddrW + 1)'(NumRegs);

  state_t state_q, state_d;

  logic [SyncStages-1:0] sck_sync, csb_sync, mosi_sync;
  logic sck_d, csb_d;
  logic sck_s, csb_s, mosi_s;
  logic sck_rise, sck_fall, csb_fall;

  logic [7:0] regs [NumRegs];
  logic [7:0] shift_in;
  logic [7:0] byte_in;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [6:0] addr_q, addr_next;
  logic       addr_in_range;
  logic [7:0] rd_byte;
  logic [7:0] tx_shift;
  logic       tx_load;

  assign sck_s  = sck_sync[SyncStages-1];
  assign csb_s  = csb_sync[SyncStages-1];
  assign mosi_s = mosi_sync[SyncStages-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csb_fall = ~csb_s & csb_d;

  assign byte_in   = {shift_in[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state_q != IDLE);

  assign addr_in_range = {1'b0, addr_q} < NumRegsB;
  assign rd_byte = addr_in_range ? regs[addr_q[AddrW-1:0]] : 8'hFF;

`ifdef SPI_TGT_AUTOINC_EN
  localparam logic [6:0] AddrLast = 7'(NumRegs - 1);
  assign addr_next = (addr_q == AddrLast) ? 7'd0 : addr_q + 7'd1;
`else
  assign addr_next = addr_q;
`endif

  assign spi_miso_oe_o = ~csb_s;
  assign rd_data_o = ({1'b0, rd_addr_i} < NumRegsA) ? regs[rd_addr_i] : 8'h00;

  // Synchronise the SPI pins and keep the previous sample for edge detection.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      csb_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csb_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
      csb_sync  <= {csb_sync[SyncStages-2:0], spi_csb_i};
      mosi_sync <= {mosi_sync[SyncStages-2:0], spi_mosi_i};
      sck_d     <= sck_s;
      csb_d     <= csb_s;
    end
  end

  // Frame state register.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: deselect always wins over edge processing.
  always_comb begin
    state_d = state_q;
    if (csb_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (csb_fall) state_d = CMD;
        CMD:     if (byte_done) state_d = byte_in[7] ? RD : WR;
        default: state_d = state_q;
      endcase
    end
  end

  // Shift-in, register writes, read shift-out and status outputs.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= ResetVal[i];
      shift_in   <= '0;
      bit_cnt    <= '0;
      addr_q     <= '0;
      tx_shift   <= '0;
      tx_load    <= 1'b0;
      spi_miso_o <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      if (csb_s) begin
        // Deselected: any partial byte is dropped.
        bit_cnt    <= '0;
        tx_load    <= 1'b0;
        spi_miso_o <= 1'b0;
      end else if (csb_fall) begin
        bit_cnt    <= '0;
        tx_load    <= 1'b0;
        spi_miso_o <= 1'b0;
        err_o      <= 1'b0;
      end else if (state_q != IDLE) begin
        if (sck_rise) begin
          shift_in <= byte_in;
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD: begin
              addr_q  <= byte_in[6:0];
              tx_load <= byte_in[7];
            end
            WR: begin
              if (addr_in_range) begin
                regs[addr_q[AddrW-1:0]] <= byte_in;
                wr_valid_o <= 1'b1;
                wr_addr_o  <= addr_q[AddrW-1:0];
                wr_data_o  <= byte_in;
              end else begin
                err_o <= 1'b1;
              end
              addr_q <= addr_next;
            end
            RD: begin
              addr_q  <= addr_next;
              tx_load <= 1'b1;
            end
            default: ;
          endcase
        end
        // Falls that follow a byte's last rise are skipped so the freshly
        // loaded bit 7 stays on the line for the next byte's first rise.
        if (tx_load && state_q == RD) begin
          tx_load    <= 1'b0;
          tx_shift   <= rd_byte;
          spi_miso_o <= rd_byte[7];
          if (!addr_in_range) err_o <= 1'b1;
        end else if (sck_fall && state_q == RD && bit_cnt != 3'd0) begin
          tx_shift   <= {tx_shift[6:0], 1'b0};
          spi_miso_o <= tx_shift[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_target_regfile.sv
// tb/tb_spi_target_regfile.sv - self-checking bench for spi_target_regfile
module tb_spi_target_regfile;

  localparam int HALF = 8;

  logic       soc_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_csb = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic oe_bad;
  logic [7:0] model [16];
  logic [11:0] exp_q [$];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs [6];

  spi_target_regfile dut (
    .soc_clk       (soc_clk),
    .rst_n         (rst_n),
    .spi_sck_i     (spi_sck),
    .spi_csb_i     (spi_csb),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .spi_miso_oe_o (spi_miso_oe),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .wr_valid_o    (wr_valid),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .err_o         (err)
  );

  always #10 soc_clk = ~soc_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-pulse scoreboard.
  always @(negedge soc_clk) begin
    if (rst_n && wr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_pulse: unexpected addr 0x%0h data 0x%0h", wr_addr, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_pulse: got 0x%0h expected 0x%0h", {wr_addr, wr_data}, e);
        end
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (HALF) @(negedge soc_clk);
      r[i] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_bad = 1'b1;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge soc_clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] tx, input int n, output logic [31:0] rx);
    logic [7:0] r;
    rx = '0;
    oe_bad = 1'b0;
    spi_csb = 1'b0;
    repeat (HALF) @(negedge soc_clk);
    for (int k = 0; k < n; k++) begin
      send_bits(tx[31-8*k -: 8], 8, r);
      rx[31-8*k -: 8] = r;
    end
    repeat (HALF) @(negedge soc_clk);
    spi_csb = 1'b1;
    repeat (2 * HALF) @(negedge soc_clk);
  endtask

  // Host write of a burst: updates the bench model and queues expected pulses.
  task automatic host_write(input logic [6:0] a, input logic [7:0] d1, input logic [7:0] d2, input int nd);
    logic [31:0] rx;
    logic [6:0] cur;
    cur = a;
    for (int k = 0; k < nd; k++) begin
      logic [7:0] d;
      d = (k == 0) ? d1 : d2;
      if (cur < 7'd16) begin
        model[cur[3:0]] = d;
        exp_q.push_back({cur[3:0], d});
      end
`ifdef SPI_TGT_AUTOINC_EN
      cur = (cur == 7'd15) ? 7'd0 : cur + 7'd1;
`endif
    end
    frame({1'b0, a, d1, d2, 8'h00}, nd + 1, rx);
  endtask

  task automatic fab_read(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  initial begin
    logic [31:0] rx;
    logic [7:0] d;
    logic [7:0] r8;

    vecs[0] = '{8'h03, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'h07, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF};
    vecs[3] = '{8'h0F, 8'h01, 1'b0, 8'h01};
    vecs[4] = '{8'h20, 8'h33, 1'b1, 8'hFF};
    vecs[5] = '{8'h07, 8'hC3, 1'b0, 8'hC3};
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    repeat (3) @(negedge soc_clk);
    check("reset_miso", {31'd0, spi_miso}, 0);
    check("reset_oe", {31'd0, spi_miso_oe}, 0);
    check("reset_wr_valid", {31'd0, wr_valid}, 0);
    check("reset_err", {31'd0, err}, 0);
    fab_read(4'd9, d);
    check("reset_reg9", {24'd0, d}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge soc_clk);

    // Table: single-byte writes, then readback over SPI and fabric.
    for (int i = 0; i < 6; i++) begin
      host_write(vecs[i].cmd[6:0], vecs[i].data, 8'h00, 1);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      fab_read(vecs[i].cmd[3:0], d);
      check($sformatf("vec%0d_fab", i), {24'd0, d}, {24'd0, vecs[i].exp_rd});
      if (!vecs[i].exp_err) begin
        frame({1'b1, vecs[i].cmd[6:0], 24'h0}, 2, rx);
        check($sformatf("vec%0d_miso", i), {24'd0, rx[23:16]}, {24'd0, vecs[i].exp_rd});
        check($sformatf("vec%0d_rd_err", i), {31'd0, err}, 0);
      end
    end

    // Read of reg 3 with output-enable tracking.
    host_write(7'h03, 8'hA5, 8'h00, 1);
    frame({8'h83, 24'h0}, 2, rx);
    check("t2_miso", {24'd0, rx[23:16]}, 32'hA5);
    check("t2_oe_in_frame", {31'd0, oe_bad}, 0);
    check("t2_oe_after", {31'd0, spi_miso_oe}, 0);

    // Burst write across the top address.
    host_write(7'h0F, 8'h11, 8'h22, 2);
    fab_read(4'hF, d);
`ifdef SPI_TGT_AUTOINC_EN
    check("t3_reg15", {24'd0, d}, 32'h11);
    fab_read(4'h0, d);
    check("t3_reg0", {24'd0, d}, 32'h22);
    frame({8'h8F, 24'h0}, 3, rx);
    check("t3_burst_rd", {16'd0, rx[23:8]}, 32'h1122);
`else
    check("t3_reg15", {24'd0, d}, 32'h22);
    fab_read(4'h0, d);
    check("t3_reg0", {24'd0, d}, 32'hFF);
    frame({8'h8F, 24'h0}, 3, rx);
    check("t3_burst_rd", {16'd0, rx[23:8]}, 32'h2222);
`endif

    // Deselect after 4 data bits.
    spi_csb = 1'b0;
    repeat (HALF) @(negedge soc_clk);
    send_bits(8'h04, 8, r8);
    send_bits(8'h5A, 4, r8);
    repeat (HALF) @(negedge soc_clk);
    spi_csb = 1'b1;
    repeat (2 * HALF) @(negedge soc_clk);
    fab_read(4'd4, d);
    check("t4_reg4", {24'd0, d}, 0);
    check("t4_fsm_idle", 32'(dut.state_q), 0);
    check("t4_miso", {31'd0, spi_miso}, 0);
    host_write(7'h04, 8'h66, 8'h00, 1);
    fab_read(4'd4, d);
    check("t4_reg4_after", {24'd0, d}, 32'h66);

    // Out-of-range read, then error cleared by the next frame.
    frame({8'h90, 24'h0}, 2, rx);
    check("t5_miso_ff", {24'd0, rx[23:16]}, 32'hFF);
    check("t5_err_set", {31'd0, err}, 1);
    host_write(7'h01, 8'h5C, 8'h00, 1);
    check("t5_err_clr", {31'd0, err}, 0);

    // Reset in the middle of a read frame.
    spi_csb = 1'b0;
    repeat (HALF) @(negedge soc_clk);
    send_bits(8'h83, 8, r8);
    send_bits(8'h00, 3, r8);
    rst_n = 1'b0;
    @(negedge soc_clk);
    check("t6_oe", {31'd0, spi_miso_oe}, 0);
    check("t6_miso", {31'd0, spi_miso}, 0);
    fab_read(4'd3, d);
    check("t6_reg3", {24'd0, d}, 0);
    spi_csb = 1'b1;
    repeat (4) @(negedge soc_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (4) @(negedge soc_clk);
    host_write(7'h02, 8'h77, 8'h00, 1);
    frame({8'h82, 24'h0}, 2, rx);
    check("t6_after_rd", {24'd0, rx[23:16]}, 32'h77);

    check("pulses_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
